// File: rtl/fredkin_pkg.sv
// ============================================================================
//  Module      : fredkin_pkg
//  Description : Shared types and helpers for the Fredkin swap sorter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fredkin_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Number of compare/swap cycles for an odd-even transposition sort.
  function automatic int sort_cycles(input int depth);
    return (depth / 2) * (depth - 1);
  endfunction

  // Swap control: strict unsigned compare, so equal words stay put.
  // Callers zero-extend their words to 64 bits.
  function automatic logic swap_ctrl(input logic [63:0] lo_word, input logic [63:0] hi_word);
    return lo_word > hi_word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fredkin_word_swap.sv
// ============================================================================
//  Module      : fredkin_word_swap
//  Description : Word-wide conditional swap built from one Fredkin cell per bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fredkin_word_swap #(
  parameter int WIDTH = 8
) (
  input  logic             a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    assign p[g] = a;
    assign q[g] = (~a & b[g]) | (a & c[g]);
    assign r[g] = (~a & c[g]) | (a & b[g]);
  end

endmodule

`default_nettype wire

// File: rtl/fredkin_sort_ctrl.sv
// ============================================================================
//  Module      : fredkin_sort_ctrl
//  Description : Load / odd-even transposition sort / drain controller that
//                time-shares one fredkin_word_swap over a register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fredkin_sort_ctrl
  import fredkin_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [7:0]       swap_cnt
);

  localparam int             c_iw       = $clog2(DEPTH);
  localparam logic [c_iw-1:0] c_last_idx = c_iw'(DEPTH - 1);
  localparam int             c_last_phs = DEPTH - 1;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_bank [DEPTH];
  logic [c_iw-1:0]   r_wr_idx;
  logic [c_iw-1:0]   r_rd_idx;
  logic [c_iw-1:0]   r_pair;
  logic [c_iw-1:0]   r_phase;
  logic [7:0]        r_swap_cnt;

  logic              w_in_acc;
  logic              w_out_acc;
  logic              w_load_last;
  logic              w_drain_last;
  logic              w_phase_end;
  logic              w_sort_done;
  logic [c_iw-1:0]   w_pair_hi;
  logic              w_a;
  logic [WIDTH-1:0]  w_b;
  logic [WIDTH-1:0]  w_c;
  logic [WIDTH-1:0]  w_p;
  logic [WIDTH-1:0]  w_q;
  logic [WIDTH-1:0]  w_r;

  assign w_in_acc     = in_valid  && (r_state == LOAD);
  assign w_out_acc    = out_ready && (r_state == DRAIN);
  assign w_load_last  = w_in_acc  && (r_wr_idx == c_last_idx);
  assign w_drain_last = w_out_acc && (r_rd_idx == c_last_idx);

  // Even phases end at pair DEPTH-2, odd phases at DEPTH-3. With DEPTH=2 the
  // odd phase is empty, so the sort finishes after phase 0.
  assign w_phase_end = r_phase[0] ? (int'(r_pair) >= DEPTH - 3) : (int'(r_pair) >= DEPTH - 2);
  assign w_sort_done = w_phase_end && ((int'(r_phase) == c_last_phs) || (DEPTH == 2));

  assign w_pair_hi = r_pair + c_iw'(1);
  assign w_b       = r_bank[r_pair];
  assign w_c       = r_bank[w_pair_hi];
  assign w_a       = swap_ctrl(64'(w_b), 64'(w_c));

  fredkin_word_swap #(
    .WIDTH (WIDTH)
  ) u_swap (
    .a (w_a),
    .b (w_b),
    .c (w_c),
    .p (w_p),
    .q (w_q),
    .r (w_r)
  );

  assert property (@(posedge clk) disable iff (!rst_n) w_p == {WIDTH{w_a}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      LOAD: begin
        in_ready = 1'b1;
        if (w_load_last) w_next = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (w_sort_done) w_next = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (w_drain_last) w_next = LOAD;
      end
      default: w_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_bank[k] <= '0;
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_pair     <= '0;
      r_phase    <= '0;
      r_swap_cnt <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_in_acc) begin
            r_bank[r_wr_idx] <= in_data;
            r_wr_idx         <= w_load_last ? '0 : r_wr_idx + c_iw'(1);
          end
          if (w_load_last) begin
            r_swap_cnt <= '0;
            r_pair     <= '0;
            r_phase    <= '0;
          end
        end
        SORT: begin
          r_bank[r_pair]    <= w_q;
          r_bank[w_pair_hi] <= w_r;
          if (w_a) r_swap_cnt <= r_swap_cnt + 8'd1;
          if (w_phase_end) begin
            r_phase <= r_phase + c_iw'(1);
            r_pair  <= r_phase[0] ? '0 : c_iw'(1);
          end else begin
            r_pair  <= r_pair + c_iw'(2);
          end
        end
        DRAIN: begin
          if (w_out_acc) r_rd_idx <= w_drain_last ? '0 : r_rd_idx + c_iw'(1);
          if (w_drain_last) r_wr_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_bank[r_rd_idx];
  assign swap_cnt = r_swap_cnt;

endmodule

`default_nettype wire
